// File: rtl/qdec_cabac_package.sv
// Shared types for the CABAC transform-unit scheduler: FSM states, component
// codes and the bit layout of the residual job mask.
package qdec_cabac_package;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CBF       = 3'd1,
      ST_DQP       = 3'd2,
      ST_CQP       = 3'd3,
      ST_RES_ISSUE = 3'd4,
      ST_RES_WAIT  = 3'd5,
      ST_ENDING    = 3'd6
   } t_state_tu_sched;

   localparam logic [1:0] COMP_Y  = 2'd0;
   localparam logic [1:0] COMP_CB = 2'd1;
   localparam logic [1:0] COMP_CR = 2'd2;

   // Job mask bit positions; lower index is issued first.
   localparam int MB_Y   = 0;
   localparam int MB_CB0 = 1;
   localparam int MB_CB1 = 2;
   localparam int MB_CR0 = 3;
   localparam int MB_CR1 = 4;

endpackage

// File: rtl/qdec_tu_job_pick.sv
// Lowest-set-bit pick over the 5-bit residual job mask.
module qdec_tu_job_pick
   import qdec_cabac_package::*;
(
   input  logic [4:0] mask,
   output logic [1:0] comp,
   output logic       sub_idx,
   output logic [4:0] clr
);

   always_comb begin
      clr     = mask & (~mask + 5'd1);
      comp    = COMP_Y;
      if (clr[MB_CB0] | clr[MB_CB1]) comp = COMP_CB;
      if (clr[MB_CR0] | clr[MB_CR1]) comp = COMP_CR;
      sub_idx = clr[MB_CB1] | clr[MB_CR1];
   end

endmodule

// File: rtl/qdec_tu_sched.sv
// Transform-unit scheduler: builds the residual job mask from the cbf flags,
// sequences the delta-QP / chroma-QP-offset decoders, then issues one residual job at a time.
module qdec_tu_sched
   import qdec_cabac_package::*;
#(
   parameter int LOG2W  = 3,
   parameter bit EN_422 = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tu_start,
   input  logic             abort,
   input  logic [LOG2W-1:0] log2TrafoSize,
   input  logic [1:0]       blkIdx,
   input  logic [1:0]       chroma_format_idc,
   input  logic             cbf_luma,
   input  logic [1:0]       cbf_cb,
   input  logic [1:0]       cbf_cr,
   input  logic [1:0]       parent_cbf_cb,
   input  logic [1:0]       parent_cbf_cr,
   input  logic             cu_transquant_bypass_flag,
   input  logic             cu_qp_delta_enabled_flag,
   input  logic             cu_chroma_qp_offset_enabled_flag,
   input  logic             is_cu_qp_delta_coded,
   input  logic             is_cu_chroma_qp_offset_coded,
   output logic             dqp_start,
   output logic             cqp_start,
   output logic             res_start,
   input  logic             dqp_done,
   input  logic             cqp_done,
   input  logic             res_done,
   output logic [1:0]       res_comp,
   output logic [LOG2W-1:0] res_log2size,
   output logic             res_sub_idx,
   output logic             tu_busy,
   output logic             set_qp_delta_coded,
   output logic             set_cqp_offset_coded,
   output logic             tu_done_intr
);

   t_state_tu_sched  state_q, state_d;
   logic [4:0]       mask_q, new_mask, pick_in, pick_clr;
   logic [LOG2W-1:0] log2_q, csize_q, new_csize, job_size;
   logic             cqp_need_q;
   logic [1:0]       cb_sel, cr_sel, pick_comp;
   logic             use_pair, chroma_ok, cbf_chroma, dqp_need_in, cqp_need_in;
   logic             in_cbf, pick_sub;
   logic             go_dqp, go_cqp, go_res, set_dq, set_cq, intr;

   // Chroma job selection from the raw inputs; only meaningful while in CBF.
   always_comb begin
      use_pair  = (chroma_format_idc == 2'd2) && EN_422;
      chroma_ok = 1'b0;
      cb_sel    = cbf_cb;
      cr_sel    = cbf_cr;
      new_csize = log2TrafoSize;
      case (chroma_format_idc)
         2'd3: chroma_ok = 1'b1;
         2'd1, 2'd2: begin
            if (log2TrafoSize > LOG2W'(2)) begin
               chroma_ok = 1'b1;
               new_csize = log2TrafoSize - LOG2W'(1);
            end else if (blkIdx == 2'd3) begin
               chroma_ok = 1'b1;
               cb_sel    = parent_cbf_cb;
               cr_sel    = parent_cbf_cr;
               new_csize = LOG2W'(2);
            end
         end
         default: ;
      endcase
      new_mask[MB_Y]   = cbf_luma;
      new_mask[MB_CB0] = chroma_ok & cb_sel[0];
      new_mask[MB_CB1] = chroma_ok & use_pair & cb_sel[1];
      new_mask[MB_CR0] = chroma_ok & cr_sel[0];
      new_mask[MB_CR1] = chroma_ok & use_pair & cr_sel[1];
      cbf_chroma  = |new_mask[4:1];
      dqp_need_in = cu_qp_delta_enabled_flag & ~is_cu_qp_delta_coded;
      cqp_need_in = cbf_chroma & cu_chroma_qp_offset_enabled_flag &
                    ~cu_transquant_bypass_flag & ~is_cu_chroma_qp_offset_coded;
   end

   // The first job may be issued straight out of CBF, so the picker sees the fresh mask there.
   assign in_cbf   = (state_q == ST_CBF);
   assign pick_in  = in_cbf ? new_mask : mask_q;
   assign job_size = (pick_comp == COMP_Y) ? (in_cbf ? log2TrafoSize : log2_q)
                                           : (in_cbf ? new_csize : csize_q);

   qdec_tu_job_pick u_pick (
      .mask    (pick_in),
      .comp    (pick_comp),
      .sub_idx (pick_sub),
      .clr     (pick_clr)
   );

   always_comb begin
      state_d = state_q;
      go_dqp  = 1'b0;
      go_cqp  = 1'b0;
      go_res  = 1'b0;
      set_dq  = 1'b0;
      set_cq  = 1'b0;
      intr    = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (tu_start) state_d = ST_CBF;
            ST_CBF: begin
               if (new_mask == 5'd0)  state_d = ST_ENDING;
               else if (dqp_need_in) begin state_d = ST_DQP; go_dqp = 1'b1; end
               else if (cqp_need_in) begin state_d = ST_CQP; go_cqp = 1'b1; end
               else                  begin state_d = ST_RES_ISSUE; go_res = 1'b1; end
            end
            ST_DQP: if (dqp_done && !dqp_start) begin
               set_dq = 1'b1;
               if (cqp_need_q) begin state_d = ST_CQP; go_cqp = 1'b1; end
               else            begin state_d = ST_RES_ISSUE; go_res = 1'b1; end
            end
            ST_CQP: if (cqp_done && !cqp_start) begin
               set_cq  = 1'b1;
               state_d = ST_RES_ISSUE;
               go_res  = 1'b1;
            end
            ST_RES_ISSUE: state_d = ST_RES_WAIT;
            ST_RES_WAIT: if (res_done) begin
               if (mask_q != 5'd0) begin state_d = ST_RES_ISSUE; go_res = 1'b1; end
               else                state_d = ST_ENDING;
            end
            ST_ENDING: begin state_d = ST_IDLE; intr = 1'b1; end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q              <= ST_IDLE;
         mask_q               <= '0;
         log2_q               <= '0;
         csize_q              <= '0;
         cqp_need_q           <= 1'b0;
         dqp_start            <= 1'b0;
         cqp_start            <= 1'b0;
         res_start            <= 1'b0;
         res_comp             <= COMP_Y;
         res_log2size         <= '0;
         res_sub_idx          <= 1'b0;
         tu_busy              <= 1'b0;
         set_qp_delta_coded   <= 1'b0;
         set_cqp_offset_coded <= 1'b0;
         tu_done_intr         <= 1'b0;
      end else begin
         state_q              <= state_d;
         tu_busy              <= (state_d != ST_IDLE);
         dqp_start            <= go_dqp;
         cqp_start            <= go_cqp;
         res_start            <= go_res;
         set_qp_delta_coded   <= set_dq;
         set_cqp_offset_coded <= set_cq;
         tu_done_intr         <= intr;
         if (abort)
            mask_q <= '0;
         else if (in_cbf || go_res)
            mask_q <= go_res ? (pick_in & ~pick_clr) : pick_in;
         if (in_cbf && !abort) begin
            log2_q     <= log2TrafoSize;
            csize_q    <= new_csize;
            cqp_need_q <= cqp_need_in;
         end
         if (go_res) begin
            res_comp     <= pick_comp;
            res_log2size <= job_size;
            res_sub_idx  <= pick_sub;
         end
      end
   end

endmodule

// File: tb/tb_qdec_tu_sched.sv
// Self-checking bench for qdec_tu_sched: directed cases plus random TUs checked
// against a job-list model derived from the cbf rules.
module tb_qdec_tu_sched;

   logic       clk = 1'b0;
   logic       rst_n, tu_start, abort;
   logic [2:0] log2TrafoSize;
   logic [1:0] blkIdx, chroma_format_idc;
   logic       cbf_luma;
   logic [1:0] cbf_cb, cbf_cr, parent_cbf_cb, parent_cbf_cr;
   logic       cu_transquant_bypass_flag, cu_qp_delta_enabled_flag;
   logic       cu_chroma_qp_offset_enabled_flag, is_cu_qp_delta_coded, is_cu_chroma_qp_offset_coded;
   logic       dqp_start, cqp_start, res_start, dqp_done, cqp_done, res_done;
   logic [1:0] res_comp;
   logic [2:0] res_log2size;
   logic       res_sub_idx, tu_busy, set_qp_delta_coded, set_cqp_offset_coded, tu_done_intr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int fmt, log2, blk;
      bit luma;
      bit [1:0] cb, cr, pcb, pcr;
      bit bypass, dqp_en, cqp_en, dqp_coded, cqp_coded;
   } cfg_t;

   typedef struct { int comp; int size; int sub; } job_t;

   job_t exp_q[$];
   bit   exp_dqp, exp_cqp;

   qdec_tu_sched dut (
      .clk(clk), .rst_n(rst_n), .tu_start(tu_start), .abort(abort),
      .log2TrafoSize(log2TrafoSize), .blkIdx(blkIdx), .chroma_format_idc(chroma_format_idc),
      .cbf_luma(cbf_luma), .cbf_cb(cbf_cb), .cbf_cr(cbf_cr),
      .parent_cbf_cb(parent_cbf_cb), .parent_cbf_cr(parent_cbf_cr),
      .cu_transquant_bypass_flag(cu_transquant_bypass_flag),
      .cu_qp_delta_enabled_flag(cu_qp_delta_enabled_flag),
      .cu_chroma_qp_offset_enabled_flag(cu_chroma_qp_offset_enabled_flag),
      .is_cu_qp_delta_coded(is_cu_qp_delta_coded),
      .is_cu_chroma_qp_offset_coded(is_cu_chroma_qp_offset_coded),
      .dqp_start(dqp_start), .cqp_start(cqp_start), .res_start(res_start),
      .dqp_done(dqp_done), .cqp_done(cqp_done), .res_done(res_done),
      .res_comp(res_comp), .res_log2size(res_log2size), .res_sub_idx(res_sub_idx),
      .tu_busy(tu_busy), .set_qp_delta_coded(set_qp_delta_coded),
      .set_cqp_offset_coded(set_cqp_offset_coded), .tu_done_intr(tu_done_intr)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Expected job list straight from the cbf rules (4:2:2 pairing enabled).
   task automatic model(input cfg_t c);
      bit has_c, pair, chroma_any;
      bit [1:0] cb, cr;
      int csz;
      exp_q.delete();
      has_c = 0; pair = (c.fmt == 2); cb = c.cb; cr = c.cr; csz = 0;
      if (c.luma) exp_q.push_back('{0, c.log2, 0});
      if (c.fmt == 3) begin has_c = 1; csz = c.log2; pair = 0; end
      else if (c.fmt != 0) begin
         if (c.log2 > 2) begin has_c = 1; csz = c.log2 - 1; end
         else if (c.blk == 3) begin has_c = 1; csz = 2; cb = c.pcb; cr = c.pcr; end
      end
      chroma_any = 0;
      if (has_c) begin
         if (cb[0])         begin exp_q.push_back('{1, csz, 0}); chroma_any = 1; end
         if (pair && cb[1]) begin exp_q.push_back('{1, csz, 1}); chroma_any = 1; end
         if (cr[0])         begin exp_q.push_back('{2, csz, 0}); chroma_any = 1; end
         if (pair && cr[1]) begin exp_q.push_back('{2, csz, 1}); chroma_any = 1; end
      end
      exp_dqp = (exp_q.size() != 0) && c.dqp_en && !c.dqp_coded;
      exp_cqp = (exp_q.size() != 0) && chroma_any && c.cqp_en && !c.bypass && !c.cqp_coded;
   endtask

   task automatic apply(input cfg_t c);
      log2TrafoSize = 3'(c.log2); blkIdx = 2'(c.blk); chroma_format_idc = 2'(c.fmt);
      cbf_luma = c.luma; cbf_cb = c.cb; cbf_cr = c.cr;
      parent_cbf_cb = c.pcb; parent_cbf_cr = c.pcr;
      cu_transquant_bypass_flag = c.bypass; cu_qp_delta_enabled_flag = c.dqp_en;
      cu_chroma_qp_offset_enabled_flag = c.cqp_en;
      is_cu_qp_delta_coded = c.dqp_coded; is_cu_chroma_qp_offset_coded = c.cqp_coded;
   endtask

   function automatic cfg_t rand_cfg();
      cfg_t c;
      c.fmt = $urandom_range(0, 3); c.log2 = $urandom_range(2, 5); c.blk = $urandom_range(0, 3);
      c.luma = 1'($urandom); c.cb = 2'($urandom); c.cr = 2'($urandom);
      c.pcb = 2'($urandom); c.pcr = 2'($urandom);
      c.bypass = 1'($urandom); c.dqp_en = 1'($urandom); c.cqp_en = 1'($urandom);
      c.dqp_coded = 1'($urandom); c.cqp_coded = 1'($urandom);
      return c;
   endfunction

   // Full TU: start, optional DQP/CQP, each residual job, then the done interrupt.
   task automatic run_tu(input cfg_t c);
      model(c);
      apply(c);
      tu_start = 1; tick(); tu_start = 0;
      chk("busy_cbf", tu_busy, 1);
      tick();
      apply(rand_cfg());   // CBF has latched everything it needs
      if (exp_dqp) begin
         chk("dqp_start", dqp_start, 1);
         chk("dqp_cqp_quiet", cqp_start, 0);
         chk("dqp_res_quiet", res_start, 0);
         dqp_done = 1; tick(); dqp_done = 0;
         chk("dqp_same_cycle_done", set_qp_delta_coded, 0);
         chk("dqp_pulse", dqp_start, 0);
         idle($urandom_range(0, 2));
         dqp_done = 1; tick(); dqp_done = 0;
         chk("set_qp_delta", set_qp_delta_coded, 1);
      end
      if (exp_cqp) begin
         chk("cqp_start", cqp_start, 1);
         chk("cqp_res_quiet", res_start, 0);
         cqp_done = 1; tick(); cqp_done = 0;
         chk("cqp_same_cycle_done", set_cqp_offset_coded, 0);
         chk("cqp_pulse", cqp_start, 0);
         idle($urandom_range(0, 2));
         cqp_done = 1; tick(); cqp_done = 0;
         chk("set_cqp_offset", set_cqp_offset_coded, 1);
      end
      foreach (exp_q[i]) begin
         chk("res_start", res_start, 1);
         chk("res_comp", res_comp, exp_q[i].comp);
         chk("res_log2size", res_log2size, exp_q[i].size);
         chk("res_sub_idx", res_sub_idx, exp_q[i].sub);
         res_done = 1; tick(); res_done = 0;
         chk("res_pulse", res_start, 0);
         idle($urandom_range(0, 2));
         chk("res_wait_quiet", res_start, 0);
         res_done = 1; tick(); res_done = 0;
      end
      chk("end_no_start", res_start | dqp_start | cqp_start, 0);
      chk("end_busy", tu_busy, 1);
      chk("end_intr_early", tu_done_intr, 0);
      tick();
      chk("tu_done_intr", tu_done_intr, 1);
      chk("idle_busy", tu_busy, 0);
      tick();
      chk("intr_pulse", tu_done_intr, 0);
   endtask

   initial begin
      cfg_t c;
      rst_n = 0; tu_start = 0; abort = 0; dqp_done = 0; cqp_done = 0; res_done = 0;
      c = '{fmt: 0, log2: 2, blk: 0, luma: 0, cb: 0, cr: 0, pcb: 0, pcr: 0,
            bypass: 0, dqp_en: 0, cqp_en: 0, dqp_coded: 0, cqp_coded: 0};
      apply(c);
      idle(3);
      chk("rst_busy", tu_busy, 0);
      chk("rst_starts", {dqp_start, cqp_start, res_start}, 0);
      chk("rst_res_fields", {res_comp, res_log2size, res_sub_idx}, 0);
      chk("rst_status", {set_qp_delta_coded, set_cqp_offset_coded, tu_done_intr}, 0);
      rst_n = 1;
      tick();

      // Case B: 4:2:2 pairs, dqp already coded
      c = '{fmt: 2, log2: 3, blk: 0, luma: 0, cb: 2'b11, cr: 2'b10, pcb: 0, pcr: 0,
            bypass: 0, dqp_en: 1, cqp_en: 0, dqp_coded: 1, cqp_coded: 0};
      run_tu(c);
      // Case C: 4x4 luma block, chroma only on blkIdx 3 from parent flags
      c = '{fmt: 1, log2: 2, blk: 2, luma: 0, cb: 2'b11, cr: 2'b11, pcb: 2'b11, pcr: 2'b11,
            bypass: 0, dqp_en: 1, cqp_en: 1, dqp_coded: 0, cqp_coded: 0};
      run_tu(c);
      c.blk = 3; c.pcb = 2'b01; c.pcr = 2'b00; c.dqp_en = 0; c.cqp_en = 0;
      run_tu(c);

      // Case D: abort together with res_done in RES_WAIT
      c = '{fmt: 0, log2: 4, blk: 0, luma: 1, cb: 0, cr: 0, pcb: 0, pcr: 0,
            bypass: 0, dqp_en: 0, cqp_en: 0, dqp_coded: 0, cqp_coded: 0};
      apply(c);
      tu_start = 1; tick(); tu_start = 0;
      tick();
      chk("abort_res_start", res_start, 1);
      tick();
      abort = 1; res_done = 1; tick(); abort = 0; res_done = 0;
      chk("abort_busy", tu_busy, 0);
      chk("abort_no_intr", tu_done_intr, 0);
      tick();
      chk("abort_no_intr2", tu_done_intr, 0);

      // Case A: full sequence dqp -> cqp -> Y, Cb, Cr
      c = '{fmt: 1, log2: 4, blk: 0, luma: 1, cb: 2'b01, cr: 2'b01, pcb: 0, pcr: 0,
            bypass: 0, dqp_en: 1, cqp_en: 1, dqp_coded: 0, cqp_coded: 0};
      run_tu(c);

      // Case E: reset while in CQP, then a stale cqp_done
      c = '{fmt: 1, log2: 3, blk: 0, luma: 0, cb: 2'b01, cr: 2'b00, pcb: 0, pcr: 0,
            bypass: 0, dqp_en: 0, cqp_en: 1, dqp_coded: 0, cqp_coded: 0};
      apply(c);
      tu_start = 1; tick(); tu_start = 0;
      tick();
      chk("e_cqp_start", cqp_start, 1);
      tick();
      rst_n = 0; tick();
      chk("e_rst_busy", tu_busy, 0);
      chk("e_rst_starts", {dqp_start, cqp_start, res_start}, 0);
      chk("e_rst_res_fields", {res_comp, res_log2size, res_sub_idx}, 0);
      chk("e_rst_status", {set_qp_delta_coded, set_cqp_offset_coded, tu_done_intr}, 0);
      rst_n = 1; cqp_done = 1; tick(); cqp_done = 0;
      chk("e_stale_done", set_cqp_offset_coded, 0);
      chk("e_stale_busy", tu_busy, 0);
      chk("e_stale_res", res_start, 0);

      for (int n = 0; n < 60; n++) run_tu(rand_cfg());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
